// File: rtl/project_pkg.sv
// Shared types for the multicycle datapath: ALU opcodes, PC update modes, FSM states.
package project_pkg;

  typedef enum logic [3:0] {
    ALU_NOP   = 4'd0,
    ALU_ADD   = 4'd1,
    ALU_SUB   = 4'd2,
    ALU_AND   = 4'd3,
    ALU_OR    = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SHL   = 4'd6,
    ALU_SHR   = 4'd7,
    ALU_PASSB = 4'd8
  } e_alu_op;

  typedef enum logic [1:0] {
    PC_INC = 2'd0,
    PC_JMP = 2'd1,
    PC_BZ  = 2'd2,
    PC_BNZ = 2'd3
  } e_pc_src;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MEM  = 2'd2,
    S_WB   = 2'd3
  } e_dp_state;

endpackage

// File: rtl/alu_p.sv
// Combinational ALU: result, zero flag, and carry/borrow for ADD/SUB only.
module alu_p
  import project_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  e_alu_op          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry
);

  localparam int unsigned SH_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH:0]  sum;
  logic [WIDTH:0]  diff;
  logic [SH_W-1:0] shamt;

  // Extra MSB of sum/diff carries the carry-out / borrow.
  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    diff   = {1'b0, a} - {1'b0, b};
    shamt  = b[SH_W-1:0];
    result = a;
    carry  = 1'b0;
    case (op)
      ALU_NOP:   result = a;
      ALU_ADD: begin
        result = sum[WIDTH-1:0];
        carry  = sum[WIDTH];
      end
      ALU_SUB: begin
        result = diff[WIDTH-1:0];
        carry  = diff[WIDTH];
      end
      ALU_AND:   result = a & b;
      ALU_OR:    result = a | b;
      ALU_XOR:   result = a ^ b;
      ALU_SHL:   result = a << shamt;
      ALU_SHR:   result = a >> shamt;
      ALU_PASSB: result = b;
      default:   result = a;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/datapath_mc.sv
// Multicycle datapath: accepts one decoded command per handshake and runs it
// through EXEC -> (MEM) -> WB, with a stall-tolerant req/ack memory port.
module datapath_mc
  import project_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned NREGS = 4,
  parameter  int unsigned PC_W  = 8,
  localparam int unsigned RA_W  = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [RA_W-1:0]  rs,
  input  logic [RA_W-1:0]  rt,
  input  logic [RA_W-1:0]  rd,
  input  logic [WIDTH-1:0] imm,
  input  e_alu_op          alu_op,
  input  logic             alu_src,
  input  logic             reg_wr,
  input  logic             mem_rd,
  input  logic             mem_wr,
  input  e_pc_src          pc_src,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ack,
  output logic [PC_W-1:0]  pc,
  output logic [WIDTH-1:0] alu_out,
  output logic             alu_zero,
  output logic             alu_carry,
  output logic             done,
  input  logic [RA_W-1:0]  dbg_ra,
  output logic [WIDTH-1:0] dbg_rd
);

  e_dp_state state;
  e_dp_state state_nxt;

  logic [WIDTH-1:0] regs [NREGS];

  // Command fields captured at accept
  logic [RA_W-1:0]  rd_q;
  logic [WIDTH-1:0] imm_q;
  e_alu_op          op_q;
  e_pc_src          pc_src_q;
  logic             reg_wr_q;
  logic             mem_rd_q;
  logic             mem_wr_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] st_q;
  logic [WIDTH-1:0] ld_q;

  logic [WIDTH-1:0] alu_res;
  logic             alu_z;
  logic             alu_c;
  logic [PC_W-1:0]  pc_inc;
  logic [PC_W-1:0]  pc_tgt;
  logic [PC_W-1:0]  pc_nxt;
  logic [WIDTH-1:0] wb_data;
  logic             accept;

  alu_p #(.WIDTH(WIDTH)) u_alu (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .result (alu_res),
    .zero   (alu_z),
    .carry  (alu_c)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (cmd_valid) state_nxt = S_EXEC;
      S_EXEC:  state_nxt = (mem_rd_q | mem_wr_q) ? S_MEM : S_WB;
      S_MEM:   if (mem_ack) state_nxt = S_WB;
      S_WB:    state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Control outputs decoded from the state register
  always_comb begin
    cmd_ready = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: cmd_ready = 1'b1;
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = mem_wr_q;
      end
      S_WB:    done = 1'b1;
      default: ;
    endcase
  end

  assign accept    = (state == S_IDLE) && cmd_valid;
  assign mem_addr  = alu_out;
  assign mem_wdata = st_q;
  assign dbg_rd    = regs[dbg_ra];

  // A store wins over a load when both are set, so writeback then takes alu_out.
  assign wb_data = (mem_rd_q && !mem_wr_q) ? ld_q : alu_out;

  // PC update uses the flags registered in this command's EXEC.
  always_comb begin
    pc_inc = pc + PC_W'(1);
    pc_tgt = PC_W'(imm_q);
    case (pc_src_q)
      PC_INC:  pc_nxt = pc_inc;
      PC_JMP:  pc_nxt = pc_tgt;
      PC_BZ:   pc_nxt = alu_zero ? pc_tgt : pc_inc;
      PC_BNZ:  pc_nxt = alu_zero ? pc_inc : pc_tgt;
      default: pc_nxt = pc_inc;
    endcase
  end

  // Datapath registers and register file
  always_ff @(posedge clk) begin
    if (rst) begin
      regs      <= '{default: '0};
      pc        <= '0;
      alu_out   <= '0;
      alu_zero  <= 1'b0;
      alu_carry <= 1'b0;
      rd_q      <= '0;
      imm_q     <= '0;
      op_q      <= ALU_NOP;
      pc_src_q  <= PC_INC;
      reg_wr_q  <= 1'b0;
      mem_rd_q  <= 1'b0;
      mem_wr_q  <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      st_q      <= '0;
      ld_q      <= '0;
    end else begin
      if (accept) begin
        rd_q     <= rd;
        imm_q    <= imm;
        op_q     <= alu_op;
        pc_src_q <= pc_src;
        reg_wr_q <= reg_wr;
        mem_rd_q <= mem_rd;
        mem_wr_q <= mem_wr;
        a_q      <= regs[rs];
        b_q      <= alu_src ? regs[rt] : imm;
        st_q     <= regs[rt];
      end
      if (state == S_EXEC) begin
        alu_out   <= alu_res;
        alu_zero  <= alu_z;
        alu_carry <= alu_c;
      end
      if (state == S_MEM && mem_ack) begin
        ld_q <= mem_rdata;
      end
      if (state == S_WB) begin
        if (reg_wr_q) begin
          regs[rd_q] <= wb_data;
        end
        pc <= pc_nxt;
      end
    end
  end

endmodule

// File: doc/datapath_mc.md
Name: datapath_mc

Overview:
Parametrised multicycle datapath. It executes one externally decoded command per valid/ready handshake, sequencing the phases EXEC → MEM → WB with an internal FSM. The MEM phase talks to data memory over a req/ack handshake with arbitrary wait states. It sits between the controller (command source) and data memory, and generalises the single-cycle 8-bit datapath with:
- width and register-count parameters;
- a separate destination register;
- conditional branches;
- carry flag;
- stall-tolerant memory.

Parameters:
- WIDTH, 8, data/register/ALU width in bits.
- NREGS, 4, register count; must be ≥2 and a power of two. RA_W = $clog2(NREGS) is a localparam.
- PC_W, 8, program counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  datapath idle and accepting.
- rs  in  RA_W  source A register.
- rt  in  RA_W  source B register.
- rd  in  RA_W  destination register.
- imm  in  WIDTH  immediate / branch target.
- alu_op  in  e_alu_op  ALU operation.
- alu_src  in  1  1 = B from rt, 0 = B from imm.
- reg_wr  in  1  write rd in WB.
- mem_rd  in  1  load.
- mem_wr  in  1  store.
- pc_src  in  e_pc_src  PC update mode.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write.
- mem_addr  out  WIDTH  address.
- mem_wdata  out  WIDTH  store data.
- mem_rdata  in  WIDTH  load data, valid with ack.
- mem_ack  in  1  completes request.
- pc  out  PC_W  program counter.
- alu_out  out  WIDTH  registered ALU result.
- alu_zero  out  1  registered zero flag.
- alu_carry  out  1  registered carry/borrow flag.
- done  out  1  one-cycle completion pulse.
- dbg_ra  in  RA_W  debug read address.
- dbg_rd  out  WIDTH  combinational regfile[dbg_ra].

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: all registers, pc, alu_out, alu_zero, alu_carry = 0; mem_req/mem_we/done = 0; FSM in IDLE; cmd_ready = 1 in the first cycle after reset.
- FSM states: IDLE, EXEC, MEM, WB.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid, latch all command fields plus A = reg[rs] and B = (alu_src ? reg[rt] : imm), then go to EXEC.
- EXEC:
  - Compute the ALU result; register alu_out, alu_zero and alu_carry.
  - Go to MEM if mem_rd|mem_wr, else go to WB.
- MEM:
  - mem_req = 1, mem_addr = alu_out, mem_wdata = reg[rt] value latched at accept, mem_we = latched mem_wr.
  - These outputs hold stable until a cycle with mem_ack = 1.
  - On that cycle, latch mem_rdata and go to WB. Ack in the same cycle as MEM entry is legal (zero wait states).
- WB:
  - If reg_wr, write reg[rd] = (mem_rd & !mem_wr) ? loaded data : alu_out.
  - Update pc; done = 1; return to IDLE. cmd_ready is 0 during WB; the next command can be accepted the cycle after.
- Latency:
  - Accept on edge T0, done high in cycle T0+2 without memory.
  - With memory, done is high in cycle T0+3+w, where w = wait cycles before ack.
- cmd_ready = 0 outside IDLE; cmd_valid is ignored there. mem_ack outside MEM is ignored.
- mem_rd & mem_wr both set: store is performed; writeback uses alu_out.
- PC update in WB, using flags from this command's EXEC:
  - PC_INC: pc + 1.
  - PC_JMP: imm[PC_W-1:0], zero-extended if WIDTH < PC_W.
  - PC_BZ: branch to imm if alu_zero, else pc + 1.
  - PC_BNZ: branch to imm if !alu_zero, else pc + 1.
  - PC arithmetic wraps modulo 2^PC_W.
- ALU (WIDTH bits, results modulo 2^WIDTH):
  - ADD: carry = carry-out.
  - SUB: A − B; carry = borrow (A < B unsigned).
  - AND, OR, XOR.
  - SHL, SHR: logical shift by B[$clog2(WIDTH)-1:0].
  - PASSB: out = B.
  - NOP: out = A.
  - carry = 0 for all ops except ADD/SUB.
  - zero = (result == 0).
- Reset mid-operation: on the rst edge, the FSM returns to IDLE and mem_req drops. An outstanding request is abandoned: no register write, no pc change, no done.

Decomposition:
- project_pkg holds:
  - e_alu_op (4-bit: ALU_NOP, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SHL, ALU_SHR, ALU_PASSB);
  - e_pc_src (2-bit: PC_INC, PC_JMP, PC_BZ, PC_BNZ);
  - e_dp_state.
- One sub-module, alu_p #(WIDTH): combinational op, a, b → result, zero, carry.
- The register file stays inline as an array in datapath_mc.

Test Plan:
1. Reset, then accept rd=1, imm=0x7A, alu_src=0, PASSB, reg_wr → done at T0+2; dbg_ra=1 gives 0x7A; pc=1.
2. r1=0xF0, r2=0x20: ADD rs=1, rt=2, alu_src=1, rd=3 → r3=0x10, alu_carry=1, alu_zero=0. SUB 0x10−0x10 → alu_zero=1, carry=0.
3. Store r3 to addr imm=0x40 (ADD r0=0 + imm), mem_wr, ack after 3 wait cycles:
   - mem_req/addr=0x40/wdata=0x10 stable for 4 cycles;
   - done at T0+6; cmd_ready=0 throughout.
4. Load with ack in the MEM-entry cycle, mem_rdata=0x9A, rd=2 → r2=0x9A, done at T0+3.
5. PC_BZ imm=0x20 after SUB of equal values → pc=0x20. PC_BNZ on same → pc+1. From pc=0xFF, PC_INC → pc=0x00.
6. Assert rst during MEM wait → next cycle mem_req=0, pc=0, all regs 0, no done, cmd_ready=1. A late mem_ack is ignored.
